// File: rtl/stage_tracker_pkg.sv
// stage_tracker_pkg
//   Shared types and helpers for the stage tracker.
//   - state_t   : game FSM states (IDLE, PLAY, WON)
//   - needHits  : number of hits required to clear stage k
package stage_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2
  } state_t;

  localparam int DEF_BASE_HITS = 2;
  localparam int DEF_HIT_STEP  = 1;

  // Stage k needs base_hits + k*hit_step hits; later stages get harder.
  function automatic int needHits(input int k,
                                  input int base_hits = DEF_BASE_HITS,
                                  input int hit_step  = DEF_HIT_STEP);
    return base_hits + k * hit_step;
  endfunction

endpackage

// File: rtl/stage_tracker_rise_detect.sv
// rise_detect
//   Registered rising-edge detector. The input level is sampled every clock
//   and compared with the previous sample; rise is high for one cycle after
//   a low sample is followed by a high sample. A level held high yields a
//   single rise.
// Ports:
//   clk    : clock, rising edge
//   resetN : asynchronous active-low reset (clears both samples)
//   din    : level input
//   rise   : one-cycle rising-edge indication, driven from registers
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic rise
);

  logic sample_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sample_reg <= 1'b0;
      prev_reg   <= 1'b0;
    end else begin
      sample_reg <= din;
      prev_reg   <= sample_reg;
    end
  end

  assign rise = sample_reg & ~prev_reg;

endmodule

// File: rtl/stage_tracker.sv
// stage_tracker
//   Tracks progress through NUM_STAGES game stages. Each trueStack rising
//   edge is a hit; when the hits in the current stage reach the stage's
//   requirement the stage is cleared (one-cycle clear pulse) and the
//   thermometer-coded stage output advances. Clearing the last stage wins
//   the game. start (re)starts a game from any state.
//
//   Optional feature: define STAGE_TRACKER_MISS_PENALTY_EN to make each
//   falseStack rising edge in PLAY reset the hit counter (miss beats a hit
//   in the same cycle). Without it falseStack has no effect.
//
// Ports:
//   clk        : clock, rising edge
//   resetN     : asynchronous active-low reset
//   start      : start / restart a game
//   trueStack  : correct-stack level, rising edge = hit
//   falseStack : wrong-stack level, rising edge = miss
//   stage      : thermometer code, stage k active => bits [k:0] set
//   clear      : one-cycle pulse per cleared stage
//   gameWon    : high once all stages are cleared
//   hitCount   : hits accumulated in the current stage
module stage_tracker
  import stage_tracker_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int BASE_HITS  = 2,
  parameter int HIT_STEP   = 1,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  trueStack,
  input  logic                  falseStack,
  output logic [NUM_STAGES-1:0] stage,
  output logic                  clear,
  output logic                  gameWon,
  output logic [CNT_W-1:0]      hitCount
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [NUM_STAGES-1:0] STAGE_FIRST = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  state_t                  state_reg, state_next;
  logic [NUM_STAGES-1:0]   stage_reg, stage_next;
  logic [IDX_W-1:0]        idx_reg,   idx_next;
  logic [CNT_W-1:0]        hit_reg,   hit_next;
  logic                    clear_reg, clear_next;
  logic                    won_reg,   won_next;

  logic                    hit_rise;
  logic                    miss_rise;
  logic                    miss_event;
  logic [CNT_W:0]          hit_inc;
  logic                    stage_done;

  // Per-stage requirement table, built at elaboration time.
  logic [CNT_W-1:0] need_tbl [NUM_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_need
      assign need_tbl[gi] = CNT_W'(needHits(gi, BASE_HITS, HIT_STEP));
    end
  endgenerate

  rise_detect u_true_rise (
    .clk    (clk),
    .resetN (resetN),
    .din    (trueStack),
    .rise   (hit_rise)
  );

  rise_detect u_false_rise (
    .clk    (clk),
    .resetN (resetN),
    .din    (falseStack),
    .rise   (miss_rise)
  );

`ifdef STAGE_TRACKER_MISS_PENALTY_EN
  assign miss_event = miss_rise;
`else
  // Misses carry no penalty in this build; the detector output is sunk.
  logic unused_miss;
  assign unused_miss = miss_rise;
  assign miss_event  = 1'b0;
`endif

  // One extra bit so the compare against the requirement cannot wrap.
  assign hit_inc    = {1'b0, hit_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign stage_done = (hit_inc == {1'b0, need_tbl[idx_reg]});

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      idx_reg   <= '0;
      hit_reg   <= '0;
      clear_reg <= 1'b0;
      won_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      idx_reg   <= idx_next;
      hit_reg   <= hit_next;
      clear_reg <= clear_next;
      won_reg   <= won_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    idx_next   = idx_reg;
    hit_next   = hit_reg;
    clear_next = 1'b0;
    won_next   = won_reg;

    if (start) begin
      // start wins over any hit or miss in the same cycle, from any state.
      state_next = PLAY;
      stage_next = STAGE_FIRST;
      idx_next   = '0;
      hit_next   = '0;
      won_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
        end
        PLAY: begin
          if (miss_event) begin
            hit_next = '0;
          end else if (hit_rise) begin
            if (stage_done) begin
              clear_next = 1'b1;
              hit_next   = '0;
              // Shifting a 1 into an all-ones code leaves it all-ones.
              stage_next = {stage_reg[NUM_STAGES-2:0], 1'b1};
              if (idx_reg == LAST_IDX) begin
                state_next = WON;
                won_next   = 1'b1;
              end else begin
                idx_next = idx_reg + IDX_ONE;
              end
            end else begin
              hit_next = hit_inc[CNT_W-1:0];
            end
          end
        end
        WON: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign stage    = stage_reg;
  assign clear    = clear_reg;
  assign gameWon  = won_reg;
  assign hitCount = hit_reg;

endmodule

// File: doc/stage_tracker.md
STAGE_TRACKER -- requirements
Module: stage_tracker

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5; number of game stages, range 2..16.
REQ-002 SHALL have parameter BASE_HITS, default 2; hits required to clear stage 0, minimum 1.
REQ-003 SHALL have parameter HIT_STEP, default 1; extra hits required per later stage, so stage k needs BASE_HITS + k*HIT_STEP.
REQ-004 SHALL have parameter CNT_W, default 5; hit counter width, at least clog2 of the largest requirement plus 1.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-006 SHALL have port resetN, input, 1 bit; reset that is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit; a level-high pulse that starts or restarts a game.
REQ-008 SHALL have port trueStack, input, 1 bit; correct-stack level, where each rising edge counts as one hit.
REQ-009 SHALL have port falseStack, input, 1 bit; wrong-stack level, where each rising edge counts as one miss.
REQ-010 SHALL have port stage, output, NUM_STAGES bits; thermometer code in which stage k active means bits [k:0] = 1.
REQ-011 SHALL have port clear, output, 1 bit; a one-cycle pulse on each stage cleared.
REQ-012 SHALL have port gameWon, output, 1 bit; a level that is high once all stages are cleared.
REQ-013 SHALL have port hitCount, output, CNT_W bits; hits accumulated in the current stage.

Function
REQ-014 SHALL have FSM states IDLE, PLAY, WON.
REQ-015 SHALL go from IDLE to PLAY on start, with stage = 1, hitCount = 0.
REQ-016 SHALL, in PLAY, register the trueStack rising edge (previous-sample compare) and raise hitCount in the cycle after the edge is sampled.
REQ-017 SHALL, when the raised count would equal the requirement for stage k, instead assert clear for exactly one cycle in that cycle, set hitCount to 0 and shift a 1 into stage.
REQ-018 SHALL, on a clear at the last stage (k = NUM_STAGES-1), keep stage all-ones, go to WON and set gameWon = 1.
REQ-019 SHALL, in WON, ignore hits and misses; start returns to PLAY at stage 1 with gameWon = 0.
REQ-020 SHALL, on start in PLAY, restart at stage 1 with hitCount 0 and no clear pulse.
REQ-021 SHALL, in IDLE, ignore trueStack and falseStack.
REQ-022 SHALL count a held-high trueStack as a single hit; a new hit needs a low sample and then a high sample.
REQ-023 SHALL never let hitCount wrap; it stays below the requirement of the current stage.

Reset
REQ-024 SHALL, while resetN = 0, immediately force state IDLE, stage = 0, clear = 0, gameWon = 0, hitCount = 0, and edge registers = 0.
REQ-025 SHALL abandon any game in progress on reset mid-game; the first cycle after release is IDLE.

Configuration
REQ-026 SHALL support macro STAGE_TRACKER_MISS_PENALTY_EN.
REQ-027 SHALL, when the macro is defined, set hitCount to 0 on a falseStack rising edge in PLAY, and give the miss priority over a hit in the same cycle, so the result is 0.
REQ-028 SHALL, when the macro is undefined, ignore falseStack, keep the port, and leave it unread.

Structure
REQ-029 SHALL put the state enum and the requirement function needHits(k) in package stage_tracker_pkg.
REQ-030 SHALL implement the rising-edge detection in one sub-module, rise_detect, instantiated twice: once for trueStack and once for falseStack.

Verification (defaults: requirements 2,3,4,5,6)
REQ-031 SHALL cover: reset, then start, then 2 trueStack pulses -> clear high 1 cycle, stage = 00011, hitCount = 0.
REQ-032 SHALL cover: 20 total pulses from start -> clear pulses at hits 2,5,9,14,20, stage = 11111, gameWon = 1, and further pulses have no effect.
REQ-033 SHALL cover: trueStack held high 10 cycles -> hitCount increments by exactly 1.
REQ-034 SHALL cover: with the macro defined, 2 hits then a falseStack edge at stage 1 -> hitCount = 0, stage unchanged; without the macro, hitCount stays 2.
REQ-035 SHALL cover: resetN low mid-stage 3 (asynchronous, between edges) -> outputs 0 at once; IDLE after release, and hits ignored until start.
REQ-036 SHALL cover: start pulse from WON -> gameWon = 0, stage = 00001, hitCount = 0.
